mbist_addr_cmp: RTL and testbench
=================================

Name: mbist_addr_cmp

Overview:
- Datapath stage directly downstream of the MBIST march controller. Consumes its counter controls (reset/preset/en/up_down) and access controls (read/write/data).
- Generates the memory address, write data and enables, and returns carry (terminal count) to the controller.
- Compares read data against the expected background, returns is_equal, and logs the first failing address/data plus an error count.

Parameters:
- ADDR_W, 4, address/counter width; memory depth = 2**ADDR_W.
- DATA_W, 8, memory word width.
- RD_LAT, 1, memory read latency in clk cycles from mem_re to mem_rdata valid; legal range 1..4.
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ctr_reset  in  1  synchronous load of address counter to 0.
- ctr_preset  in  1  synchronous load of address counter to all-ones.
- en  in  1  counter step / access enable.
- up_down  in  1  1 = increment, 0 = decrement.
- read  in  1  read access request.
- write  in  1  write access request.
- data  in  1  background bit; replicated across DATA_W.
- carry  out  1  terminal count reached in the current direction.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_re.
- is_equal  out  1  0 only in a cycle where a valid compare mismatches.
- log_clr  in  1  synchronous clear of fail log and error count.
- fail_valid  out  1  sticky; a mismatch has been logged.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_exp  out  DATA_W  expected word at first mismatch.
- fail_got  out  DATA_W  read word at first mismatch.
- err_cnt  out  ERR_W  mismatch count, saturating.

Behaviour:
- Reset values: addr=0, pipeline valids=0, fail_valid=0, fail_addr=0, fail_exp=0, fail_got=0, err_cnt=0. Combinational outputs follow from these values: carry=0, mem_we=0, mem_re=0, is_equal=1.
- Counter update priority per edge: ctr_reset > ctr_preset > en. With en, up_down=1 gives addr+1 and up_down=0 gives addr-1, modulo 2**ADDR_W (wraps MAX->0 and 0->MAX).
- carry is combinational: en & ((up_down & addr==MAX) | (!up_down & addr==0)). It is asserted during the last access of a pass, so the controller advances on that edge.
- mem_addr = addr, combinational, zero latency.
- mem_we = en & write.
- mem_re = en & read & !write; write wins when read and write are both asserted, and no compare is scheduled.
- mem_wdata = {DATA_W{data}}.
- Compare pipeline: RD_LAT-deep shift of {valid=mem_re, addr, exp={DATA_W{data}}}. The stage-RD_LAT entry is the compare point.
- is_equal = !cmp_valid | (mem_rdata == cmp_exp), combinational from pipeline registers and mem_rdata.
- On mismatch at a clock edge:
  - err_cnt increments, saturating at 2**ERR_W-1.
  - If fail_valid=0: capture fail_addr, fail_exp and fail_got, and set fail_valid. Later mismatches do not overwrite the log.
- log_clr: clears fail log and err_cnt on the next edge. If a mismatch occurs in the same cycle, log_clr wins; the mismatch is not counted.
- Counter loads (ctr_reset/ctr_preset) do not flush the pipeline; in-flight reads still compare.
- rst mid-operation: pipeline flushed, so no stale compare after release.
- Unsigned arithmetic throughout; no X propagation from mem_rdata when cmp_valid=0.

Decomposition:
- Shared package mbist_pkg holds:
  - march element encoding (W0, R0, W1, R1);
  - default ADDR_W, DATA_W, RD_LAT;
  - function bg_word(bit) returning the replicated background word.
- One sub-module: mbist_addr_ctr, the up/down loadable counter with combinational carry. Compare pipeline and fail log stay in the top.

Test Plan:
- ADDR_W=4: ctr_reset, then en=1, up_down=1, write=1, data=0 for 16 cycles. Expected: mem_addr 0..15, mem_we=1 each cycle, carry=1 only at addr=15, wrap to 0.
- ctr_preset, then en=1, up_down=0, read=1, memory all-zero, RD_LAT=1. Expected: addresses 15..0, carry at addr=0, is_equal=1 throughout, err_cnt=0.
- Same read pass with memory word 6 = 0x04. Expected: is_equal=0 one cycle after mem_addr=6; fail_addr=6, fail_exp=0x00, fail_got=0x04, fail_valid=1, err_cnt=1.
- Two mismatches at addr 3 then 9. Expected: log holds addr 3, err_cnt=2. Then log_clr. Expected: all log outputs 0.
- read=1 and write=1 simultaneously. Expected: mem_we=1, mem_re=0, no compare, is_equal stays 1.
- RD_LAT=3, rst asserted with two reads in flight. Expected: after release, is_equal=1 and err_cnt=0 even with corrupt mem_rdata.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: march element encoding, default widths and the
// background-word helper used by the address/compare datapath.
package mbist_pkg;

    typedef enum logic [1:0] {
        ElemW0 = 2'd0,
        ElemR0 = 2'd1,
        ElemW1 = 2'd2,
        ElemR1 = 2'd3
    } march_elem_e;

    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefRdLat = 1;
    localparam int unsigned DefErrW  = 8;

    function automatic logic [DefDataW-1:0] bg_word(input logic bg_bit);
        return {DefDataW{bg_bit}};
    endfunction

endpackage

// File: rtl/mbist_addr_ctr.sv
// Loadable up/down address counter with combinational terminal-count carry.
module mbist_addr_ctr
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctr_reset,
    input  logic              ctr_preset,
    input  logic              en,
    input  logic              up_down,
    output logic [ADDR_W-1:0] addr,
    output logic              carry
);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (ctr_reset) begin
            addr_d = '0;
        end else if (ctr_preset) begin
            addr_d = '1;
        end else if (en) begin
            addr_d = up_down ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Raised during the last access of a pass so the controller steps on that edge.
    assign carry = en & ((up_down & (addr_q == '1)) | (!up_down & (addr_q == '0)));
    assign addr  = addr_q;

endmodule

// File: rtl/mbist_addr_cmp.sv
// MBIST datapath: address generation, write/read enables, read-data compare
// pipeline and a first-fail log with a saturating error counter.
module mbist_addr_cmp
    import mbist_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned RD_LAT = DefRdLat,
    parameter int unsigned ERR_W  = DefErrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctr_reset,
    input  logic              ctr_preset,
    input  logic              en,
    input  logic              up_down,
    input  logic              read,
    input  logic              write,
    input  logic              data,
    output logic              carry,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              is_equal,
    input  logic              log_clr,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [ERR_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] bg;
    logic [ADDR_W-1:0] addr;

    if (DATA_W == DefDataW) begin : g_pkg_bg
        assign bg = bg_word(data);
    end else begin : g_rep_bg
        assign bg = {DATA_W{data}};
    end

    mbist_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .ctr_reset (ctr_reset),
        .ctr_preset(ctr_preset),
        .en        (en),
        .up_down   (up_down),
        .addr      (addr),
        .carry     (carry)
    );

    assign mem_addr  = addr;
    assign mem_we    = en & write;
    assign mem_re    = en & read & !write;
    assign mem_wdata = bg;

    logic [RD_LAT-1:0]             pipe_valid_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q;
    logic [RD_LAT-1:0][DATA_W-1:0] pipe_exp_q;

    // Counter loads leave this shift alone; only rst flushes in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_addr_q  <= '0;
            pipe_exp_q   <= '0;
        end else begin
            pipe_valid_q[0] <= mem_re;
            pipe_addr_q[0]  <= addr;
            pipe_exp_q[0]   <= bg;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_addr_q[i]  <= pipe_addr_q[i-1];
                pipe_exp_q[i]   <= pipe_exp_q[i-1];
            end
        end
    end

    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;
    logic              mismatch;

    assign cmp_valid = pipe_valid_q[RD_LAT-1];
    assign cmp_addr  = pipe_addr_q[RD_LAT-1];
    assign cmp_exp   = pipe_exp_q[RD_LAT-1];
    // Select first so an idle, undriven read bus never reaches is_equal.
    assign mismatch  = cmp_valid ? (mem_rdata != cmp_exp) : 1'b0;
    assign is_equal  = !mismatch;

    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_got_d   = fail_got_q;
        err_cnt_d    = err_cnt_q;
        if (log_clr) begin
            fail_valid_d = 1'b0;
            fail_addr_d  = '0;
            fail_exp_d   = '0;
            fail_got_d   = '0;
            err_cnt_d    = '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (!fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_addr_d  = cmp_addr;
                fail_exp_d   = cmp_exp;
                fail_got_d   = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_got_q   <= fail_got_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_addr  = fail_addr_q;
    assign fail_exp   = fail_exp_q;
    assign fail_got   = fail_got_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mbist_addr_cmp.sv
// Bench for mbist_addr_cmp: two instances (read latency 1 and 3) share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_mbist_addr_cmp;

    logic clk = 1'b0;
    logic rst, ctr_reset, ctr_preset, en, up_down, read, write, data, log_clr;
    logic corrupt;

    always #5 clk = ~clk;

    logic       carry1, we1, re1, eq1, fv1;
    logic [3:0] addr1, fa1;
    logic [7:0] wd1, fe1, fg1, ec1, rdata1;
    logic       carry3, we3, re3, eq3, fv3;
    logic [3:0] addr3, fa3;
    logic [7:0] wd3, fe3, fg3, ec3, rdata3;

    mbist_addr_cmp #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1), .ERR_W(8)) dut1 (
        .clk(clk), .rst(rst), .ctr_reset(ctr_reset), .ctr_preset(ctr_preset), .en(en),
        .up_down(up_down), .read(read), .write(write), .data(data), .carry(carry1),
        .mem_addr(addr1), .mem_we(we1), .mem_re(re1), .mem_wdata(wd1), .mem_rdata(rdata1),
        .is_equal(eq1), .log_clr(log_clr), .fail_valid(fv1), .fail_addr(fa1),
        .fail_exp(fe1), .fail_got(fg1), .err_cnt(ec1)
    );

    mbist_addr_cmp #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3), .ERR_W(8)) dut3 (
        .clk(clk), .rst(rst), .ctr_reset(ctr_reset), .ctr_preset(ctr_preset), .en(en),
        .up_down(up_down), .read(read), .write(write), .data(data), .carry(carry3),
        .mem_addr(addr3), .mem_we(we3), .mem_re(re3), .mem_wdata(wd3), .mem_rdata(rdata3),
        .is_equal(eq3), .log_clr(log_clr), .fail_valid(fv3), .fail_addr(fa3),
        .fail_exp(fe3), .fail_got(fg3), .err_cnt(ec3)
    );

    // Memory: written only by the stimulus process; read paths of depth 1 and 3.
    logic [7:0] mem [16];
    logic [7:0] r3a, r3b, r3c;
    always @(posedge clk) begin
        rdata1 <= mem[addr1];
        r3a    <= mem[addr3];
        r3b    <= r3a;
        r3c    <= r3b;
    end
    assign rdata3 = corrupt ? 8'hFF : r3c;

    // Reference model: per instance a queue of outstanding reads with due cycle.
    typedef struct {
        int         due;
        logic [3:0] addr;
        logic [7:0] exp;
        logic [7:0] got;
    } rd_t;

    rd_t  pend0[$];
    rd_t  pend1[$];
    int   lat [2] = '{1, 3};
    int   m_addr;
    logic m_fv [2];
    int   m_fa [2], m_fe [2], m_fg [2], m_err [2];
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend0.delete();
        pend1.delete();
        m_addr = 0;
        for (int k = 0; k < 2; k++) begin
            m_fv[k] = 1'b0; m_fa[k] = 0; m_fe[k] = 0; m_fg[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic chk_inst(input int k, input logic obs_eq, input logic obs_fv,
                            input logic [3:0] obs_fa, input logic [7:0] obs_fe,
                            input logic [7:0] obs_fg, input logic [7:0] obs_ec,
                            input logic exp_eq);
        string p;
        p = (k == 0) ? "lat1" : "lat3";
        chk({p, " is_equal"}, obs_eq, exp_eq);
        chk({p, " fail_valid"}, obs_fv, m_fv[k]);
        chk({p, " fail_addr"}, obs_fa, m_fa[k]);
        chk({p, " fail_exp"}, obs_fe, m_fe[k]);
        chk({p, " fail_got"}, obs_fg, m_fg[k]);
        chk({p, " err_cnt"}, obs_ec, m_err[k]);
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, move memory.
    task automatic tick();
        logic       e_carry, e_we, e_re;
        logic [7:0] bg;
        logic       act [2];
        logic       mis [2];
        rd_t        front [2];
        @(negedge clk);
        bg      = data ? 8'hFF : 8'h00;
        e_we    = en && write;
        e_re    = en && read && !write;
        e_carry = en && ((up_down && m_addr == 15) || (!up_down && m_addr == 0));
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0;
            mis[k] = 1'b0;
            if (k == 0 && pend0.size() > 0 && pend0[0].due == cyc) begin
                act[k] = 1'b1; front[k] = pend0[0];
            end
            if (k == 1 && pend1.size() > 0 && pend1[0].due == cyc) begin
                act[k] = 1'b1; front[k] = pend1[0];
            end
            if (act[k]) mis[k] = (front[k].got != front[k].exp);
        end
        chk("mem_addr", addr1, m_addr);
        chk("mem_addr lat3", addr3, m_addr);
        chk("carry", carry1, e_carry);
        chk("carry lat3", carry3, e_carry);
        chk("mem_we", we1, e_we);
        chk("mem_re", re1, e_re);
        chk("mem_re lat3", re3, e_re);
        chk("mem_wdata", wd1, bg);
        chk_inst(0, eq1, fv1, fa1, fe1, fg1, ec1, !mis[0]);
        chk_inst(1, eq3, fv3, fa3, fe3, fg3, ec3, !mis[1]);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (act[k]) begin
                    if (k == 0) void'(pend0.pop_front()); else void'(pend1.pop_front());
                end
                if (log_clr) begin
                    m_fv[k] = 1'b0; m_fa[k] = 0; m_fe[k] = 0; m_fg[k] = 0; m_err[k] = 0;
                end else if (mis[k]) begin
                    if (m_err[k] < 255) m_err[k]++;
                    if (!m_fv[k]) begin
                        m_fv[k] = 1'b1;
                        m_fa[k] = front[k].addr;
                        m_fe[k] = front[k].exp;
                        m_fg[k] = front[k].got;
                    end
                end
                if (e_re) begin
                    rd_t r;
                    r.due  = cyc + lat[k];
                    r.addr = 4'(m_addr);
                    r.exp  = bg;
                    r.got  = (k == 1 && corrupt) ? 8'hFF : mem[m_addr];
                    if (k == 0) pend0.push_back(r); else pend1.push_back(r);
                end
            end
            if (e_we) mem[m_addr] = bg;
            if (ctr_reset)       m_addr = 0;
            else if (ctr_preset) m_addr = 15;
            else if (en)         m_addr = up_down ? (m_addr + 1) % 16 : (m_addr + 15) % 16;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic read_pass(input logic up, input logic bgbit);
        if (up) ctr_reset = 1'b1; else ctr_preset = 1'b1;
        tick();
        ctr_reset = 1'b0; ctr_preset = 1'b0;
        en = 1'b1; up_down = up; read = 1'b1; data = bgbit;
        repeat (16) tick();
        en = 1'b0; read = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1; ctr_reset = 1'b0; ctr_preset = 1'b0; en = 1'b0; up_down = 1'b1;
        read = 1'b0; write = 1'b0; data = 1'b0; log_clr = 1'b0; corrupt = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        model_reset();
        #1;
        tick();
        rst = 1'b0;

        // Ascending write pass: addresses 0..15, carry at 15, wrap to 0.
        ctr_reset = 1'b1;
        tick();
        ctr_reset = 1'b0;
        en = 1'b1; up_down = 1'b1; write = 1'b1; data = 1'b0;
        repeat (16) tick();
        en = 1'b0; write = 1'b0;
        tick();

        // Clean descending read pass, then one with word 6 corrupted.
        read_pass(1'b0, 1'b0);
        mem[6] = 8'h04;
        read_pass(1'b0, 1'b0);
        chk("first fail addr 6", fa1, 4'd6);

        // Two mismatches on an ascending pass; log must keep the first.
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        mem[6] = 8'h00; mem[3] = 8'h01; mem[9] = 8'h80;
        read_pass(1'b1, 1'b0);
        chk("log holds addr 3", fa1, 4'd3);
        chk("two errors counted", ec1, 8'd2);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        tick();

        // Simultaneous read and write: write wins, nothing compared.
        en = 1'b1; read = 1'b1; write = 1'b1; data = 1'b1;
        repeat (4) tick();
        write = 1'b0; read = 1'b0; en = 1'b0;
        repeat (3) tick();

        // Reset with reads in flight on the 3-deep instance, then corrupt read data.
        mem[0] = 8'h5A; mem[1] = 8'hA5;
        ctr_reset = 1'b1;
        tick();
        ctr_reset = 1'b0;
        en = 1'b1; read = 1'b1; up_down = 1'b1; data = 1'b0;
        repeat (2) tick();
        en = 1'b0; read = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        corrupt = 1'b1;
        repeat (5) tick();
        chk("no stale compare after reset", ec3, 8'd0);
        corrupt = 1'b0;

        // Error counter saturation: every read mismatches.
        for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
        ctr_reset = 1'b1;
        tick();
        ctr_reset = 1'b0;
        en = 1'b1; read = 1'b1; up_down = 1'b1; data = 1'b0;
        repeat (300) tick();
        en = 1'b0; read = 1'b0;
        repeat (3) tick();
        chk("err_cnt saturated", ec1, 8'hFF);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 400; n++) begin
            ctr_reset  = ($urandom_range(0, 15) == 0);
            ctr_preset = ($urandom_range(0, 15) == 0);
            log_clr    = ($urandom_range(0, 23) == 0);
            en         = ($urandom_range(0, 3) != 0);
            up_down    = 1'($urandom);
            read       = 1'($urandom);
            write      = ($urandom_range(0, 3) == 0);
            data       = 1'($urandom);
            tick();
        end
        ctr_reset = 1'b0; ctr_preset = 1'b0; log_clr = 1'b0;
        en = 1'b0; read = 1'b0; write = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
